// File: rtl/freq_pkg.sv
// Shared definitions for the frequency measurement controller: FSM states and
// default limits used as parameter defaults by freq_measure_ctrl.
package freq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GATE    = 2'd1,
        CONVERT = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    // Largest edge count shown as two digits; anything above reads as overflow.
    localparam int unsigned MAX_COUNT      = 99;
    // Gate length minus one after reset: 1 ms at 12 MHz.
    localparam int unsigned DEFAULT_PERIOD = 11999;

endpackage

// File: rtl/freq_bcd_split.sv
// Splits a binary edge count into tens/units digits by repeated subtraction,
// one subtraction per cycle; done is high in the cycle the remainder drops below ten.
module freq_bcd_split #(
    parameter int unsigned COUNT_W = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] count,
    output logic               done,
    output logic [3:0]         tens,
    output logic [3:0]         units
);

    localparam logic [COUNT_W-1:0] TEN = COUNT_W'(10);

    logic               busy_q;
    logic [COUNT_W-1:0] rem_q;
    logic [3:0]         tens_q;

    assign done  = busy_q && (rem_q < TEN);
    assign tens  = tens_q;
    assign units = 4'(rem_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            rem_q  <= '0;
            tens_q <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            rem_q  <= count;
            tens_q <= '0;
        end else if (busy_q) begin
            if (rem_q >= TEN) begin
                rem_q  <= rem_q - TEN;
                tens_q <= tens_q + 4'd1;
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/freq_measure_ctrl.sv
// Gated edge counter: counts edge_pulse strobes over a programmable gate,
// converts the count to two decimal digits and publishes them with a load strobe.
module freq_measure_ctrl #(
    parameter int unsigned BITS           = 12,
    parameter int unsigned DEFAULT_PERIOD = freq_pkg::DEFAULT_PERIOD,
    parameter int unsigned MAX_COUNT      = freq_pkg::MAX_COUNT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            edge_pulse,
    input  logic            hold,
    input  logic            cfg_valid,
    input  logic [BITS-1:0] cfg_period,
    output logic            cfg_ready,
    output logic [3:0]      tens,
    output logic [3:0]      units,
    output logic            overflow,
    output logic            load,
    output logic            busy
);

    import freq_pkg::state_t;
    import freq_pkg::IDLE;
    import freq_pkg::GATE;
    import freq_pkg::CONVERT;
    import freq_pkg::PUBLISH;

    // Period registers are widened when needed so DEFAULT_PERIOD is never truncated.
    localparam int unsigned DEF_W = $clog2(DEFAULT_PERIOD + 1);
    localparam int unsigned PW    = (BITS > DEF_W) ? BITS : DEF_W;
    localparam int unsigned CW    = $clog2(MAX_COUNT + 2);

    localparam logic [PW-1:0] DEF_P = PW'(DEFAULT_PERIOD);
    localparam logic [CW-1:0] SAT   = CW'(MAX_COUNT + 1);

    state_t        state, state_nx;
    logic [PW-1:0] shadow_q;
    logic [PW-1:0] active_q;
    logic [PW-1:0] gate_cnt;
    logic [CW-1:0] edge_cnt;
    logic [CW-1:0] edge_nx;
    logic          ovf_q;
    logic [3:0]    tens_q;
    logic [3:0]    units_q;
    logic          ovf_out_q;

    logic          cfg_accept;
    logic [PW-1:0] cfg_clamped;
    logic [PW-1:0] shadow_eff;
    logic          gate_done;
    logic          enter_gate;
    logic          conv_done;
    logic          bcd_start;
    logic          bcd_done;
    logic [3:0]    bcd_tens;
    logic [3:0]    bcd_units;

    assign cfg_ready   = (state != GATE);
    assign cfg_accept  = cfg_valid && cfg_ready;
    assign cfg_clamped = (cfg_period == '0) ? PW'(1) : PW'(cfg_period);
    // A write accepted on the same edge a gate starts already applies to that gate.
    assign shadow_eff  = cfg_accept ? cfg_clamped : shadow_q;

    assign gate_done = (state == GATE) && (gate_cnt == active_q);
    assign edge_nx   = (edge_pulse && (edge_cnt != SAT)) ? edge_cnt + CW'(1) : edge_cnt;
    assign bcd_start = gate_done && (edge_nx != SAT);
    assign conv_done = (state == CONVERT) && (ovf_q || bcd_done);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!hold) state_nx = GATE;
            GATE:    if (gate_done) state_nx = CONVERT;
            CONVERT: if (ovf_q || bcd_done) state_nx = PUBLISH;
            PUBLISH: state_nx = hold ? IDLE : GATE;
            default: state_nx = IDLE;
        endcase
    end

    assign enter_gate = (state != GATE) && (state_nx == GATE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           shadow_q <= DEF_P;
        else if (cfg_accept) shadow_q <= cfg_clamped;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= '0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_q    <= 1'b0;
        end else if (enter_gate) begin
            active_q <= shadow_eff;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_q    <= 1'b0;
        end else if (state == GATE) begin
            gate_cnt <= gate_cnt + PW'(1);
            edge_cnt <= edge_nx;
            if (edge_nx == SAT) ovf_q <= 1'b1;
        end
    end

    freq_bcd_split #(
        .COUNT_W(CW)
    ) u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (bcd_start),
        .count (edge_nx),
        .done  (bcd_done),
        .tens  (bcd_tens),
        .units (bcd_units)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_q    <= '0;
            units_q   <= '0;
            ovf_out_q <= 1'b0;
        end else if (conv_done) begin
            tens_q    <= ovf_q ? 4'd9 : bcd_tens;
            units_q   <= ovf_q ? 4'd9 : bcd_units;
            ovf_out_q <= ovf_q;
        end
    end

    assign tens     = tens_q;
    assign units    = units_q;
    assign overflow = ovf_out_q;
    assign load     = (state == PUBLISH);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_freq_measure_ctrl.sv
// Randomised scoreboard bench for freq_measure_ctrl: the stimulus side predicts
// every measurement from the gate length and pulse count, a monitor checks each load.
module tb_freq_measure_ctrl;

    localparam int MAXC = 99;
    localparam int DEFP = 11999;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        edge_pulse = 1'b0;
    logic        hold = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [11:0] cfg_period = '0;
    logic        cfg_ready;
    logic [3:0]  tens;
    logic [3:0]  units;
    logic        overflow;
    logic        load;
    logic        busy;

    always #5 clk = ~clk;

    freq_measure_ctrl #(
        .BITS(12),
        .DEFAULT_PERIOD(DEFP),
        .MAX_COUNT(MAXC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .edge_pulse (edge_pulse),
        .hold       (hold),
        .cfg_valid  (cfg_valid),
        .cfg_period (cfg_period),
        .cfg_ready  (cfg_ready),
        .tens       (tens),
        .units      (units),
        .overflow   (overflow),
        .load       (load),
        .busy       (busy)
    );

    typedef struct {
        int t;
        int u;
        int o;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int phase = 0;              // 0 idle, 1 gate, 2 convert, 3 publish
    int shadow_m = DEFP;
    int pub_t = 0, pub_u = 0, pub_o = 0;
    int gcnt = 0, ccnt = 0;
    int cur_gate_start = 0, gate_start_act = -1;
    int last_gate_len = 0, last_conv_len = 0, last_load_cyc = -1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        edge_pulse = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = 12'($urandom);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic cfg_write(input int v);
        cfg_valid  = 1'b1;
        cfg_period = 12'(v);
        if (phase != 1) shadow_m = (v == 0) ? 1 : v;
    endtask

    // Called in an IDLE or PUBLISH cycle; the gate starts on the next cycle.
    // mode: 0 none, 1 every cycle, 2 first+last, 3 first n cycles, 4 n% density
    task automatic measure(input int mode, input int n_arg, input bit hold_mid,
                           input int wr_gate, input int wr_conv,
                           input bit rst_conv, input bit end_hold);
        int   g0, p, n, len;
        bit   pl, ovf;
        exp_t e;
        hold       = 1'b0;
        edge_pulse = 1'($urandom);
        g0 = cyc + 1;
        p  = shadow_m;
        n  = 0;
        for (int i = 0; i <= p; i++) begin
            step();
            phase = 1;
            hold  = hold_mid && (i >= p / 2);
            case (mode)
                1:       pl = 1'b1;
                2:       pl = (i == 0) || (i == p);
                3:       pl = (i < n_arg);
                4:       pl = ($urandom_range(0, 99) < n_arg);
                default: pl = 1'b0;
            endcase
            edge_pulse = pl;
            n += int'(pl);
            if (wr_gate >= 0 && i == p / 2) cfg_write(wr_gate);
        end
        ovf = (n > MAXC);
        e.t = ovf ? 9 : n / 10;
        e.u = ovf ? 9 : n % 10;
        e.o = int'(ovf);
        len = ovf ? 1 : n / 10 + 1;
        e.cyc = g0 + p + 1 + len;
        if (!rst_conv) sb.push_back(e);
        for (int j = 1; j <= len; j++) begin
            step();
            phase = 2;
            hold  = hold_mid ? 1'b1 : 1'($urandom);
            edge_pulse = 1'($urandom);
            if (j == 1 && wr_conv >= 0) cfg_write(wr_conv);
            if (rst_conv && j == 2) begin
                reset = 1'b1;
                phase = 0;
                #1;
                check("rst_tens", tens, 0);
                check("rst_units", units, 0);
                check("rst_overflow", overflow, 0);
                check("rst_load", load, 0);
                check("rst_busy", busy, 0);
                check("rst_cfg_ready", cfg_ready, 1);
                shadow_m = DEFP;
                return;
            end
        end
        step();
        phase = 3;
        hold  = hold_mid | end_hold;
        edge_pulse = 1'($urandom);
    endtask

    // Scoreboard monitor
    initial forever begin
        @(negedge clk);
        if (reset) begin
            pub_t = 0; pub_u = 0; pub_o = 0;
            gcnt = 0; ccnt = 0;
        end
        check("busy", busy, int'(phase != 0));
        check("cfg_ready", cfg_ready, int'(phase != 1));
        if (busy && !cfg_ready) begin
            if (gcnt == 0) cur_gate_start = cyc;
            gcnt++;
        end else if (gcnt != 0) begin
            last_gate_len  = gcnt;
            gate_start_act = cur_gate_start;
            gcnt = 0;
        end
        if (busy && cfg_ready && !load) ccnt++;
        if (load) begin
            last_conv_len = ccnt;
            ccnt = 0;
            last_load_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_load", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("tens", tens, mon_e.t);
                check("units", units, mon_e.u);
                check("overflow", overflow, mon_e.o);
                check("load_cycle", cyc, mon_e.cyc);
                pub_t = mon_e.t; pub_u = mon_e.u; pub_o = mon_e.o;
            end
        end else begin
            check("hold_tens", tens, pub_t);
            check("hold_units", units, pub_u);
            check("hold_overflow", overflow, pub_o);
        end
    end

    initial begin
        int c;
        bit eh;
        step();
        step();
        check("reset_tens", tens, 0);
        check("reset_units", units, 0);
        check("reset_overflow", overflow, 0);
        check("reset_load", load, 0);
        check("reset_busy", busy, 0);
        check("reset_cfg_ready", cfg_ready, 1);
        reset = 1'b0;
        step();

        // 37 pulses in a 100-cycle gate
        cfg_write(99);
        measure(3, 37, 0, -1, -1, 0, 0);
        settle();
        check("g37_gate_len", last_gate_len, 100);
        check("g37_conv_len", last_conv_len, 4);
        check("g37_load_latency", last_load_cyc - gate_start_act + 1, 105);

        // pulse every cycle of a 200-cycle gate saturates
        cfg_write(199);
        measure(1, 0, 0, -1, -1, 0, 0);
        settle();
        check("ovf200_gate_len", last_gate_len, 200);
        check("ovf200_conv_len", last_conv_len, 1);

        // exactly MAX_COUNT, then MAX_COUNT+1
        cfg_write(98);
        measure(1, 0, 0, -1, -1, 0, 0);
        settle();
        check("max_conv_len", last_conv_len, 10);
        cfg_write(99);
        measure(1, 0, 0, -1, -1, 0, 0);
        settle();
        check("max1_conv_len", last_conv_len, 1);

        // write refused mid-gate, accepted in CONVERT
        measure(4, 30, 0, 49, 49, 0, 0);
        settle();
        check("cfg_cur_gate_len", last_gate_len, 100);
        measure(4, 30, 0, -1, -1, 0, 0);
        settle();
        check("cfg_next_gate_len", last_gate_len, 50);

        // pulses on first and last gate cycle
        measure(2, 0, 0, -1, -1, 0, 0);

        // period 0 clamps to a 2-cycle gate
        cfg_write(0);
        measure(1, 0, 0, -1, -1, 0, 0);
        settle();
        check("clamp_gate_len", last_gate_len, 2);

        // hold raised mid-gate
        cfg_write(59);
        measure(4, 50, 1, -1, -1, 0, 0);
        step();
        phase = 0;
        settle();
        check("hold_idle_busy", busy, 0);
        step();
        step();
        c = cyc;
        measure(4, 40, 0, -1, -1, 0, 0);
        settle();
        check("hold_release_start", gate_start_act, c + 1);

        // randomised runs with multiple writes between gates
        for (int k = 0; k < 14; k++) begin
            eh = ($urandom_range(0, 3) == 0);
            measure(4, $urandom_range(0, 100), 0, -1,
                    ($urandom_range(0, 1) == 1) ? $urandom_range(0, 60) : -1, 0, eh);
            if (eh) begin
                for (int j = 0; j < $urandom_range(1, 4); j++) begin
                    step();
                    phase = 0;
                    hold = 1'b1;
                    edge_pulse = 1'($urandom);
                    if ($urandom_range(0, 1) == 1) cfg_write($urandom_range(0, 60));
                end
            end else if ($urandom_range(0, 1) == 1) begin
                cfg_write($urandom_range(0, 60));
            end
        end

        // reset in the middle of CONVERT
        cfg_write(39);
        measure(1, 0, 0, -1, -1, 0, 0);
        measure(1, 0, 0, -1, -1, 1, 0);
        step();
        reset = 1'b0;
        measure(4, 10, 0, -1, -1, 0, 1);
        settle();
        check("post_reset_gate_len", last_gate_len, DEFP + 1);

        step();
        phase = 0;
        step();
        step();
        settle();
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
